// File: rtl/regfile_rename_ckpt_if.sv
// Decode/commit/checkpoint bus between the front end and the renamed
// register file. master drives requests; slave is the register file.
interface regfile_rename_ckpt_if #(
  parameter int XLEN   = 32,
  parameter int REG_W  = 5,
  parameter int ROB_W  = 4,
  parameter int N_READ = 2
);
  logic                    rdy;
  logic [N_READ*REG_W-1:0] rd_idx;
  logic [N_READ*XLEN-1:0]  rd_value;
  logic [N_READ*ROB_W-1:0] rd_tag;
  logic [N_READ-1:0]       rd_busy;
  logic                    dec_valid;
  logic [REG_W-1:0]        dec_reg;
  logic [ROB_W-1:0]        dec_tag;
  logic                    cm_valid;
  logic [REG_W-1:0]        cm_reg;
  logic [ROB_W-1:0]        cm_tag;
  logic [XLEN-1:0]         cm_value;
  logic                    ckpt_save;
  logic                    ckpt_restore;
  logic                    flush;
  logic [REG_W:0]          busy_count;

  modport master (
    output rdy, rd_idx, dec_valid, dec_reg, dec_tag,
           cm_valid, cm_reg, cm_tag, cm_value,
           ckpt_save, ckpt_restore, flush,
    input  rd_value, rd_tag, rd_busy, busy_count
  );

  modport slave (
    input  rdy, rd_idx, dec_valid, dec_reg, dec_tag,
           cm_valid, cm_reg, cm_tag, cm_value,
           ckpt_save, ckpt_restore, flush,
    output rd_value, rd_tag, rd_busy, busy_count
  );
endinterface

// File: rtl/regfile_rename_ckpt.sv
// Architectural register file with rename status (value, ROB tag, busy),
// same-cycle commit bypass on reads, global flush and a single-entry
// branch checkpoint of the tag/busy state. Register 0 is hardwired zero.
module regfile_rename_ckpt #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int REG_W  = 5,
  parameter int ROB_W  = 4,
  parameter int N_READ = 2
) (
  input logic                   clk,
  input logic                   rst,
  regfile_rename_ckpt_if.slave  bus
);

  logic [XLEN-1:0]  values_q [NREG];
  logic [XLEN-1:0]  values_d [NREG];
  logic [ROB_W-1:0] tags_q [NREG];
  logic [ROB_W-1:0] tags_d [NREG];
  logic [ROB_W-1:0] snap_tags_q [NREG];
  logic [ROB_W-1:0] snap_tags_d [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  logic [NREG-1:0]  snap_busy_q, snap_busy_d;
  logic [NREG-1:0]  busy_cc, snap_busy_cc;
  logic [REG_W:0]   busy_cnt;

  // Next-state: commit value/clear first, then flush > restore > dec/save.
  always_comb begin
    values_d     = values_q;
    tags_d       = tags_q;
    snap_tags_d  = snap_tags_q;
    busy_d       = busy_q;
    snap_busy_d  = snap_busy_q;
    busy_cc      = busy_q;
    snap_busy_cc = snap_busy_q;
    if (bus.rdy) begin
      // Commit clears busy only when the committing tag is still the
      // newest producer; otherwise a younger rename keeps it busy.
      for (int i = 1; i < NREG; i++) begin
        if (bus.cm_valid && bus.cm_reg == REG_W'(i)) begin
          values_d[i] = bus.cm_value;
          if (tags_q[i] == bus.cm_tag)      busy_cc[i]      = 1'b0;
          if (snap_tags_q[i] == bus.cm_tag) snap_busy_cc[i] = 1'b0;
        end
      end
      if (bus.flush) begin
        busy_d      = '0;
        snap_busy_d = '0;
      end else if (bus.ckpt_restore) begin
        // Restored tags equal snapshot tags, so the snapshot's commit
        // clear is exactly the clear to apply on top of the restore.
        busy_d      = snap_busy_cc;
        tags_d      = snap_tags_q;
        snap_busy_d = snap_busy_cc;
      end else begin
        busy_d      = busy_cc;
        snap_busy_d = snap_busy_cc;
        // Snapshot excludes this cycle's rename write.
        if (bus.ckpt_save) begin
          snap_busy_d = busy_cc;
          snap_tags_d = tags_q;
        end
        for (int i = 1; i < NREG; i++) begin
          if (bus.dec_valid && bus.dec_reg == REG_W'(i)) begin
            busy_d[i] = 1'b1;
            tags_d[i] = bus.dec_tag;
          end
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        values_q[i]    <= '0;
        tags_q[i]      <= '0;
        snap_tags_q[i] <= '0;
      end
      busy_q      <= '0;
      snap_busy_q <= '0;
    end else begin
      values_q    <= values_d;
      tags_q      <= tags_d;
      snap_tags_q <= snap_tags_d;
      busy_q      <= busy_d;
      snap_busy_q <= snap_busy_d;
    end
  end

  // Read ports: current state plus commit bypass; index 0 and any index
  // outside the file read as zero/not busy.
  for (genvar gi = 0; gi < N_READ; gi++) begin : g_rd
    logic [REG_W-1:0] idx;
    logic [XLEN-1:0]  port_val;
    logic [ROB_W-1:0] port_tag;
    logic             port_busy;
    logic             hit;

    assign idx = bus.rd_idx[gi*REG_W +: REG_W];

    // Select the addressed register, then overlay the commit bypass.
    always_comb begin
      port_val  = '0;
      port_tag  = '0;
      port_busy = 1'b0;
      hit       = 1'b0;
      for (int i = 1; i < NREG; i++) begin
        if (idx == REG_W'(i)) begin
          hit       = 1'b1;
          port_val  = values_q[i];
          port_tag  = tags_q[i];
          port_busy = busy_q[i];
        end
      end
      if (hit && bus.cm_valid && bus.cm_reg == idx) begin
        port_val = bus.cm_value;
        if (port_busy && port_tag == bus.cm_tag) port_busy = 1'b0;
      end
    end

    assign bus.rd_value[gi*XLEN +: XLEN]   = port_val;
    assign bus.rd_tag[gi*ROB_W +: ROB_W]   = port_tag;
    assign bus.rd_busy[gi]                 = port_busy;
  end

  // Population count of busy registers 1..NREG-1.
  always_comb begin
    busy_cnt = '0;
    for (int i = 1; i < NREG; i++) begin
      busy_cnt = busy_cnt + (REG_W+1)'(busy_q[i]);
    end
  end

  assign bus.busy_count = busy_cnt;

endmodule

// File: doc/regfile_rename_ckpt.md
Name: regfile_rename_ckpt

Overview:
- Parametrised architectural register file with rename status (value, ROB tag, busy) per register.
- Serves N_READ combinational decode read ports, one decode rename write, and one ROB commit write.
- Adds same-cycle commit bypass, a global flush, and a single-entry branch checkpoint (save/restore of tag and busy state).
- Sits between decoder and ROB in the Tomasulo core.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- REG_W, 5, register index width; must satisfy 2^REG_W >= NREG.
- ROB_W, 4, ROB tag width.
- N_READ, 2, number of decode read ports.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; low means all state holds.
- rd_idx  in  N_READ*REG_W  packed read indices; port p occupies bits [p*REG_W +: REG_W].
- rd_value  out  N_READ*XLEN  per-port register value.
- rd_tag  out  N_READ*ROB_W  per-port ROB tag of the pending producer.
- rd_busy  out  N_READ  per-port busy; 1 means wait on rd_tag.
- dec_valid  in  1  rename write strobe.
- dec_reg  in  REG_W  destination register.
- dec_tag  in  ROB_W  ROB tag assigned to the destination.
- cm_valid  in  1  commit strobe.
- cm_reg  in  REG_W  committed register.
- cm_tag  in  ROB_W  committing ROB tag.
- cm_value  in  XLEN  committed value.
- ckpt_save  in  1  snapshot tags and busy bits.
- ckpt_restore  in  1  restore tags and busy bits from the snapshot (branch mispredict).
- flush  in  1  clear all busy bits (full pipeline flush).
- busy_count  out  REG_W+1  number of busy registers, combinational over current state.

Behaviour:
- Reset: all values 0, all busy 0, all tags 0, snapshot busy 0, snapshot tags 0. Hence rd_value=0, rd_busy=0, rd_tag=0, busy_count=0 in the cycle after rst.
- rst overrides rdy. rst mid-operation discards every in-flight event that cycle.
- rdy=0: no state change; read outputs stay combinationally valid.
- Reads are combinational, zero latency, and use current state plus commit bypass:
  - If cm_valid, cm_reg==rd_idx, and idx!=0: rd_value=cm_value.
  - If additionally busy[idx] and tags[idx]==cm_tag: rd_busy=0.
  - Otherwise rd_busy=busy[idx] and rd_tag=tags[idx].
  - The same-cycle dec write is never visible to same-cycle reads; sources see the old mapping.
  - Index 0 always reads value 0, busy 0, tag 0.
  - Indices >= NREG read as index 0.
- Commit (cm_valid, cm_reg!=0):
  - values[r] <= cm_value.
  - busy[r] <= 0 only if tags[r]==cm_tag; a mismatch keeps busy (a younger producer exists).
  - Also clear snapshot busy[r] if the snapshot tag[r]==cm_tag.
- Decode (dec_valid, dec_reg!=0): busy <= 1 and tag <= dec_tag. Decode beats commit on the same register in the same cycle (busy ends 1, tag=dec_tag, value=cm_value).
- ckpt_save: snapshot <= current tags/busy with this cycle's commit clear applied and this cycle's decode write excluded.
- ckpt_restore: tags/busy <= snapshot, with this cycle's commit clear applied on top. dec_valid is ignored that cycle. Values are untouched.
- Precedence, highest first:
  - rst.
  - flush: all busy <= 0, snapshot busy <= 0. dec, save and restore are ignored; the commit value is still written.
  - ckpt_restore: beats ckpt_save; the snapshot keeps only its commit update.
  - Normal dec/commit/save.
- Register 0 is never written and never busy.
- busy_count counts busy[1..NREG-1] of current state, range 0..NREG-1.

Test Plan:
- Reset, then read x5 on both ports -> value 0, busy 0; busy_count 0.
- dec x5 tag 3; next cycle commit x5 tag 3 value 0xDEADBEEF with a read of x5 the same cycle -> bypass: rd_value=0xDEADBEEF, rd_busy=0; afterwards busy 0, value held.
- dec x5 tag 3, then dec x5 tag 7, then commit x5 tag 3 value 0x11 -> x5 value 0x11, busy 1, tag 7; busy_count 1.
- dec x1 tag 2; ckpt_save together with dec x2 tag 4; commit x1 tag 2; ckpt_restore -> x1 busy 0, x2 busy 0, busy_count 0.
- dec x3 tag 1 and x4 tag 2; flush with commit x3 tag 1 value 0x55 -> all busy 0, x3 value 0x55.
- dec x0 tag 5, or commit x0 value 0x99 -> x0 reads value 0, busy 0. rdy=0 with dec x6 -> x6 stays not busy.
